// File: rtl/isp_dram_fetch_if.sv
// isp_dram_fetch_if: request, AXI4 read channel and output stream bundle for isp_dram_fetch
interface isp_dram_fetch_if;
  logic         req_valid;
  logic [3:0]   req_pic_no;
  logic         req_ready;
  logic         busy;
  logic [3:0]   arid_s_inf;
  logic [31:0]  araddr_s_inf;
  logic [7:0]   arlen_s_inf;
  logic [2:0]   arsize_s_inf;
  logic [1:0]   arburst_s_inf;
  logic         arvalid_s_inf;
  logic         arready_s_inf;
  logic [3:0]   rid_s_inf;
  logic [127:0] rdata_s_inf;
  logic [1:0]   rresp_s_inf;
  logic         rlast_s_inf;
  logic         rvalid_s_inf;
  logic         rready_s_inf;
  logic         out_valid;
  logic [127:0] out_data;
  logic         out_last;
  logic         out_ready;
  logic         fetch_err;
  modport master (
    input  req_valid, req_pic_no, arready_s_inf, rid_s_inf, rdata_s_inf, rresp_s_inf,
           rlast_s_inf, rvalid_s_inf, out_ready,
    output req_ready, busy, arid_s_inf, araddr_s_inf, arlen_s_inf, arsize_s_inf,
           arburst_s_inf, arvalid_s_inf, rready_s_inf, out_valid, out_data, out_last, fetch_err
  );
  modport slave (
    output req_valid, req_pic_no, arready_s_inf, rid_s_inf, rdata_s_inf, rresp_s_inf,
           rlast_s_inf, rvalid_s_inf, out_ready,
    input  req_ready, busy, arid_s_inf, araddr_s_inf, arlen_s_inf, arsize_s_inf,
           arburst_s_inf, arvalid_s_inf, rready_s_inf, out_valid, out_data, out_last, fetch_err
  );
endinterface

// File: rtl/isp_dram_fetch.sv
// isp_dram_fetch: AXI4 single-burst picture fetch into a small FIFO stream; RD_CHECK_EN enables sticky read-response checking
module isp_dram_fetch #(
  parameter logic [31:0] BASE_ADDR  = 32'h10000,
  parameter int          PIC_BYTES  = 3072,
  parameter int          BEATS      = 192,
  parameter int          FIFO_DEPTH = 4
) (
  input logic clk,
  input logic rst_n,
  isp_dram_fetch_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(BEATS);
  localparam logic [1:0] IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, DRAIN = 2'd3;
  logic [1:0]    state;
  logic [31:0]   addr;
  logic [CW-1:0] beat_cnt;
  logic [AW:0]   count;
  logic [AW-1:0] wp, rp;
  logic [128:0]  mem [FIFO_DEPTH];
  logic          push, pop, last_beat;
  assign last_beat         = beat_cnt == CW'(BEATS - 1);
  assign bus.req_ready     = state == IDLE;
  assign bus.busy          = state != IDLE;
  assign bus.arid_s_inf    = 4'd0;
  assign bus.arsize_s_inf  = 3'b100;
  assign bus.arburst_s_inf = 2'b01;
  assign bus.arvalid_s_inf = state == ADDR;
  assign bus.araddr_s_inf  = bus.arvalid_s_inf ? addr : 32'd0;
  assign bus.arlen_s_inf   = bus.arvalid_s_inf ? 8'(BEATS - 1) : 8'd0;
  assign bus.rready_s_inf  = state == DATA && count < (AW+1)'(FIFO_DEPTH);
  assign bus.out_valid     = count != '0;
  assign {bus.out_last, bus.out_data} = bus.out_valid ? mem[rp] : 129'd0;
  assign push = bus.rvalid_s_inf & bus.rready_s_inf;
  assign pop  = bus.out_valid & bus.out_ready;
  // request/address/data/drain sequencing and beat counting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr     <= 32'd0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          addr     <= BASE_ADDR + 32'(PIC_BYTES) * {28'd0, bus.req_pic_no};
          beat_cnt <= '0;
          state    <= ADDR;
        end
        ADDR: if (bus.arready_s_inf) state <= DATA;
        DATA: if (push) begin
          beat_cnt <= beat_cnt + 1'b1;
          state    <= last_beat ? DRAIN : DATA;
        end
        default: if (pop && count == (AW+1)'(1)) state <= IDLE;
      endcase
    end
  end
  // FIFO occupancy and pointers; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      wp    <= '0;
      rp    <= '0;
    end else begin
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      wp    <= wp + AW'(push);
      rp    <= rp + AW'(pop);
    end
  end
  // beat storage; contents are only visible through out_valid so it needs no reset
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= {last_beat, bus.rdata_s_inf};
  end
`ifdef RD_CHECK_EN
  logic err;
  // sticky flag for bad id/response or rlast out of step with the beat count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else if (push && (bus.rresp_s_inf != 2'd0 || bus.rid_s_inf != 4'd0 || bus.rlast_s_inf != last_beat)) err <= 1'b1;
  end
  assign bus.fetch_err = err;
`else
  assign bus.fetch_err = 1'b0;
`endif
endmodule

// File: tb/tb_isp_dram_fetch.sv
// tb_isp_dram_fetch: randomized AXI slave + DRAM model bench for isp_dram_fetch
module tb_isp_dram_fetch;
  localparam logic [31:0] BASE = 32'h10000;
  localparam int PIC = 3072, BEATS = 192, DEPTH = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0, failures = 0;
  bit fe_exp = 1'b0;
  always #5 clk = ~clk;
  isp_dram_fetch_if bus ();
  isp_dram_fetch dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // DRAM content: each 16-byte word is a fixed scramble of its byte address
  function automatic logic [127:0] dram(input logic [31:0] a);
    return {a, ~a, a ^ 32'hA5A5_5A5A, a * 32'd2654435761};
  endfunction
  task automatic idle_chk(input string t);
    chk({t, "_arvalid"}, bus.arvalid_s_inf, 0);
    chk({t, "_araddr"}, bus.araddr_s_inf, 0);
    chk({t, "_arlen"}, bus.arlen_s_inf, 0);
    chk({t, "_rready"}, bus.rready_s_inf, 0);
    chk({t, "_out_valid"}, bus.out_valid, 0);
    chk({t, "_out_data"}, bus.out_data, 0);
    chk({t, "_out_last"}, bus.out_last, 0);
    chk({t, "_busy"}, bus.busy, 0);
    chk({t, "_fetch_err"}, bus.fetch_err, 0);
    chk({t, "_req_ready"}, bus.req_ready, 1);
  endtask
  // one full picture fetch; stall: leading cycles with out_ready=0/rvalid=1, poke: stray request in DATA,
  // abort_at: reset once that many beats were accepted, err_beat: beat carrying rresp=2'b10
  task automatic burst(input int pic, input int rv_pct, input int or_pct, input int stall,
                       input bit poke, input int abort_at, input int err_beat);
    logic [31:0] a;
    int sent, recv, cyc;
    bit hold, set_fe;
    a = BASE + 32'(PIC) * 32'(pic);
    @(negedge clk);
    chk("req_ready_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_pic_no = pic[3:0];
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("arvalid", bus.arvalid_s_inf, 1);
    chk("busy", bus.busy, 1);
    chk("req_ready_busy", bus.req_ready, 0);
    repeat (2) begin
      chk("araddr", bus.araddr_s_inf, a);
      chk("arlen", bus.arlen_s_inf, BEATS - 1);
      chk("arsize", bus.arsize_s_inf, 3'b100);
      chk("arburst", bus.arburst_s_inf, 2'b01);
      @(negedge clk);
    end
    chk("araddr_hold", bus.araddr_s_inf, a);
    bus.arready_s_inf = 1'b1;
    @(negedge clk);
    bus.arready_s_inf = 1'b0;
    chk("ar_drop", bus.arvalid_s_inf, 0);
    sent = 0; recv = 0; cyc = 0; hold = 1'b0;
    while (recv < BEATS && cyc < 20000) begin
      chk("fetch_err", bus.fetch_err, fe_exp);
      if (stall > 0 && cyc == stall) begin
        chk("stall_accepted", sent, DEPTH);
        chk("stall_rready", bus.rready_s_inf, 0);
      end
      if (poke) begin
        bus.req_valid = cyc == 3;
        bus.req_pic_no = 4'd7;
        if (cyc == 3) chk("poke_req_ready", bus.req_ready, 0);
        if (cyc == 4) chk("poke_ignored", bus.arvalid_s_inf, 0);
      end
      if (abort_at >= 0 && sent == abort_at) begin
        rst_n = 1'b0;
        bus.rvalid_s_inf = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        fe_exp = 1'b0;
        idle_chk("abort");
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      bus.out_ready = cyc < stall ? 1'b0 : $urandom_range(99) < or_pct;
      if (bus.out_valid && bus.out_ready) begin
        chk("out_data", bus.out_data, dram(a + 32'(16 * recv)));
        chk("out_last", bus.out_last, recv == BEATS - 1);
        recv++;
      end
      if (!hold) bus.rvalid_s_inf = sent < BEATS && (cyc < stall || $urandom_range(99) < rv_pct);
      bus.rdata_s_inf = dram(a + 32'(16 * sent));
      bus.rlast_s_inf = sent == BEATS - 1;
      bus.rresp_s_inf = sent == err_beat ? 2'b10 : 2'b00;
      bus.rid_s_inf = 4'd0;
      hold = bus.rvalid_s_inf && !bus.rready_s_inf;
      set_fe = 1'b0;
      if (bus.rvalid_s_inf && bus.rready_s_inf) begin
`ifdef RD_CHECK_EN
        set_fe = sent == err_beat;
`endif
        sent++;
      end
      @(negedge clk);
      cyc++;
      if (set_fe) fe_exp = 1'b1;
    end
    bus.rvalid_s_inf = 1'b0;
    bus.out_ready = 1'b0;
    bus.req_valid = 1'b0;
    if (recv < BEATS) chk("timeout", 0, 1);
    chk("beats_accepted", sent, BEATS);
    chk("req_ready_after_drain", bus.req_ready, 1);
    chk("busy_after_drain", bus.busy, 0);
    chk("empty_after_drain", bus.out_valid, 0);
    chk("fetch_err_end", bus.fetch_err, fe_exp);
  endtask
  initial begin
    bus.req_valid = 1'b0;
    bus.req_pic_no = 4'd0;
    bus.arready_s_inf = 1'b0;
    bus.rid_s_inf = 4'd0;
    bus.rdata_s_inf = '0;
    bus.rresp_s_inf = 2'd0;
    bus.rlast_s_inf = 1'b0;
    bus.rvalid_s_inf = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    idle_chk("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    idle_chk("after_reset");
    chk("arid", bus.arid_s_inf, 0);
    burst(3, 100, 100, 0, 1'b0, -1, -1);
    burst(5, 100, 100, 20, 1'b0, -1, -1);
    burst(9, 50, 50, 0, 1'b0, -1, -1);
    burst(11, 100, 100, 0, 1'b1, -1, -1);
    burst(7, 50, 50, 0, 1'b0, -1, -1);
    burst(12, 100, 100, 0, 1'b0, 100, -1);
    burst(0, 100, 100, 0, 1'b0, -1, -1);
    burst(15, 50, 50, 0, 1'b0, -1, 5);
    rst_n = 1'b0;
    #1;
    fe_exp = 1'b0;
    idle_chk("final_reset");
    @(negedge clk);
    rst_n = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
